// File: rtl/expand_writeback_if.sv
// Bus bundle for expand_writeback: layer configuration, the upstream 1x1-expand
// beat stream, and the output-buffer write port with status flags.
// master = layer controller / upstream / observer side, slave = expand_writeback.
interface expand_writeback_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned AW    = 32
);
  logic [2:0]          firesel;
  logic [5:0]          chbase;
  logic                start;
  logic                in_valid;
  logic [LANES*16-1:0] in_data;

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [LANES*16-1:0] wr_data;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output firesel, chbase, start, in_valid, in_data,
    input  wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  firesel, chbase, start, in_valid, in_data,
    output wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/expand_writeback.sv
// expand_writeback: writes one layer of 1x1-expand filter outputs into the
// output buffer in group-major order, placed at a channel-group base so that
// several expand branches can be concatenated in one buffer.
// Optional feature: define EXPAND_WRITEBACK_RELU_EN to clamp negative lanes
// to zero on the way out; addressing and timing are identical either way.
module expand_writeback #(
  parameter int unsigned LANES = 16,
  parameter int unsigned AW    = 32
) (
  input logic               clk,
  input logic               rst,
  expand_writeback_if.slave bus
);

  localparam int unsigned DW = LANES * 16;
  localparam int unsigned PW = 12;  // pixel counter, up to 55*55-1
  localparam int unsigned GW = 3;   // group counter, up to 64/16

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Spatial input size S for each fire configuration.
  function automatic logic [5:0] size_of(input logic [2:0] sel);
    logic [5:0] s;
    case (sel)
      3'd0, 3'd1: s = 6'd55;
      3'd2, 3'd3: s = 6'd27;
      default:    s = 6'd13;
    endcase
    return s;
  endfunction

  // Number of 16-channel filter groups F/16 for each fire configuration.
  function automatic logic [GW-1:0] ngrp_of(input logic [2:0] sel);
    logic [GW-1:0] n;
    case (sel)
      3'd0:       n = GW'(4);
      3'd1:       n = GW'(1);
      3'd2, 3'd3: n = GW'(2);
      3'd4, 3'd5: n = GW'(3);
      default:    n = GW'(4);
    endcase
    return n;
  endfunction

  // Pixels per channel group, S*S.
  function automatic logic [PW-1:0] npix_of(input logic [2:0] sel);
    logic [PW-1:0] s;
    s = PW'(size_of(sel));
    return PW'(s * s);
  endfunction

  // Per-lane output processing; pass-through unless ReLU is built in.
  function automatic logic [DW-1:0] lane_proc(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef EXPAND_WRITEBACK_RELU_EN
    for (int k = 0; k < int'(LANES); k++) begin
      if (d[16*k+15]) begin
        r[16*k +: 16] = 16'h0000;
      end
    end
`endif
    return r;
  endfunction

  state_e        state_q;
  logic [2:0]    firesel_q;
  logic [PW-1:0] p_q;
  logic [GW-1:0] g_q;
  logic [AW-1:0] base_q;

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Geometry of the running layer, derived from the latched configuration.
  logic [PW-1:0] npix_c;
  logic [GW-1:0] ngrp_c;
  logic          last_pix_c;
  logic          last_grp_c;
  logic [AW-1:0] beat_addr_c;

  // Layer geometry and the address of the beat currently offered.
  always_comb begin
    npix_c      = npix_of(firesel_q);
    ngrp_c      = ngrp_of(firesel_q);
    last_pix_c  = (p_q == PW'(npix_c - PW'(1)));
    last_grp_c  = (g_q == GW'(ngrp_c - GW'(1)));
    beat_addr_c = base_q + (AW'(g_q) * AW'(npix_c)) + AW'(p_q);
  end

  // Layer FSM, beat counters and registered write port / status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      firesel_q <= 3'd0;
      p_q       <= '0;
      g_q       <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A beat arriving outside a layer is a protocol error and is dropped,
          // even when it coincides with the start pulse.
          if (bus.in_valid) begin
            err_q <= 1'b1;
          end
          if (bus.start) begin
            firesel_q <= bus.firesel;
            p_q       <= '0;
            g_q       <= '0;
            base_q    <= AW'(bus.chbase) * AW'(npix_of(bus.firesel));
            state_q   <= RUN;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          // Restarting a layer in flight is not allowed; flag and carry on.
          if (bus.start) begin
            err_q <= 1'b1;
          end
          if (bus.in_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= beat_addr_c;
            wr_data_q <= lane_proc(bus.in_data);
            if (last_pix_c) begin
              p_q <= '0;
              g_q <= g_q + GW'(1);
              if (last_grp_c) begin
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              p_q <= p_q + PW'(1);
            end
          end
        end
        FIN: begin
          if (bus.start || bus.in_valid) begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_expand_writeback.sv
// Bench for expand_writeback: random beat data and gaps, checked every cycle
// against a linear-index behavioural model, plus literal layer expectations.
module tb_expand_writeback;

  localparam int unsigned LANES = 16;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = LANES * 16;

  logic clk;
  logic rst;

  expand_writeback_if #(.LANES(LANES), .AW(AW)) bus ();

  expand_writeback #(.LANES(LANES), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int S_TAB [8] = '{55, 55, 27, 27, 13, 13, 13, 13};
  int F_TAB [8] = '{64, 16, 32, 32, 48, 48, 64, 64};

  int          m_mode;   // 0 idle, 1 layer running, 2 finishing
  int          m_idx;
  int          m_total;
  int          m_base;
  logic          e_wr_en, e_done, e_busy, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  function automatic logic [DW-1:0] ref_data(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef EXPAND_WRITEBACK_RELU_EN
    for (int k = 0; k < 16; k++)
      if (d[16*k+15]) r[16*k +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  // Expected outputs after each edge: beat index i of a layer goes to base+i.
  always @(posedge clk) begin
    e_wr_en = 1'b0;
    e_done  = 1'b0;
    if (!rst) begin
      m_mode = 0; m_idx = 0; m_total = 0; m_base = 0;
      e_addr = '0; e_data = '0; e_err = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (bus.in_valid) e_err = 1'b1;
          if (bus.start) begin
            m_total = S_TAB[bus.firesel] * S_TAB[bus.firesel] * (F_TAB[bus.firesel] / 16);
            m_base  = int'(bus.chbase) * S_TAB[bus.firesel] * S_TAB[bus.firesel];
            m_idx   = 0;
            m_mode  = 1;
          end
        end
        1: begin
          if (bus.start) e_err = 1'b1;
          if (bus.in_valid) begin
            e_wr_en = 1'b1;
            e_addr  = AW'(m_base + m_idx);
            e_data  = ref_data(bus.in_data);
            m_idx++;
            if (m_idx == m_total) begin
              m_mode = 2;
              e_done = 1'b1;
            end
          end
        end
        default: begin
          if (bus.start || bus.in_valid) e_err = 1'b1;
          m_mode = 0;
        end
      endcase
    end
    e_busy = (m_mode == 1);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("wr_en", 256'(bus.wr_en), 256'(e_wr_en));
    check("done",  256'(bus.done),  256'(e_done));
    check("busy",  256'(bus.busy),  256'(e_busy));
    check("err",   256'(bus.err),   256'(e_err));
    if (e_wr_en) begin
      check("wr_addr", 256'(bus.wr_addr), 256'(e_addr));
      check("wr_data", 256'(bus.wr_data), 256'(e_data));
    end
  end

  // ---------------- write monitor for literal checks ----------------
  logic [AW-1:0] wq [$];
  logic [DW-1:0] dq [$];
  logic done_seen, done_with_wr;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.wr_en) begin
        wq.push_back(bus.wr_addr);
        dq.push_back(bus.wr_data);
      end
      if (bus.done) begin
        done_seen    = 1'b1;
        done_with_wr = bus.wr_en;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_layer(input logic [2:0] f, input logic [5:0] c, input logic with_valid);
    wq.delete();
    dq.delete();
    done_seen    = 1'b0;
    done_with_wr = 1'b0;
    bus.firesel  = f;
    bus.chbase   = c;
    bus.start    = 1'b1;
    bus.in_valid = with_valid;
    bus.in_data  = rnd_data();
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // n beats; with gaps, idle cycles are inserted and the config inputs are scrambled.
  task automatic beats(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.firesel = 3'($urandom);
          bus.chbase  = 6'($urandom);
          tick();
        end
      end
      beat(rnd_data());
    end
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 10 && !done_seen; i++) @(negedge clk);
    check({nm, "_done_seen"}, 256'(done_seen), 256'(1));
    check({nm, "_done_with_wr"}, 256'(done_with_wr), 256'(1));
    tick();
    tick();
  endtask

  task automatic layer_check(input string nm, input int first, input int last, input int count);
    check({nm, "_count"}, 256'(wq.size()), 256'(count));
    if (wq.size() > 0) begin
      check({nm, "_first"}, 256'(wq[0]), 256'(first));
      check({nm, "_last"},  256'(wq[wq.size()-1]), 256'(last));
    end
  endtask

  task automatic check_all_zero(input string nm);
    @(negedge clk);
    check({nm, "_wr_en"},   256'(bus.wr_en),   256'(0));
    check({nm, "_wr_addr"}, 256'(bus.wr_addr), 256'(0));
    check({nm, "_wr_data"}, 256'(bus.wr_data), 256'(0));
    check({nm, "_busy"},    256'(bus.busy),    256'(0));
    check({nm, "_done"},    256'(bus.done),    256'(0));
    check({nm, "_err"},     256'(bus.err),     256'(0));
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.firesel  = 3'd0;
    bus.chbase   = 6'd0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Layer 1: 55x55, one group, back-to-back beats.
    start_layer(3'd1, 6'd0, 1'b0);
    beats(3025, 1'b0);
    wait_done("l1");
    layer_check("l1", 0, 3024, 3025);
    check("l1_err", 256'(bus.err), 256'(0));

    // Layer 2: 13x13, three groups at channel base 3, random gaps.
    start_layer(3'd4, 6'd3, 1'b0);
    beats(507, 1'b1);
    wait_done("l2");
    layer_check("l2", 507, 1013, 507);
    if (wq.size() > 169) check("l2_beat169", 256'(wq[169]), 256'(676));

    // Layer 3: lane processing on fixed lane patterns.
    start_layer(3'd6, 6'd0, 1'b0);
    d = rnd_data();
    d[15:0] = 16'h8001; d[31:16] = 16'h7FFF; d[47:32] = 16'h0000; d[63:48] = 16'hFFFF;
    beat(d);
    beats(675, 1'b1);
    wait_done("l3");
    layer_check("l3", 0, 675, 676);
    if (dq.size() > 0) begin
      w = dq[0];
`ifdef EXPAND_WRITEBACK_RELU_EN
      check("l3_lane0", 256'(w[15:0]),  256'(16'h0000));
      check("l3_lane3", 256'(w[63:48]), 256'(16'h0000));
`else
      check("l3_lane0", 256'(w[15:0]),  256'(16'h8001));
      check("l3_lane3", 256'(w[63:48]), 256'(16'hFFFF));
`endif
      check("l3_lane1", 256'(w[31:16]), 256'(16'h7FFF));
      check("l3_lane2", 256'(w[47:32]), 256'(16'h0000));
    end

    // Protocol: stray beat in IDLE, start with a beat, restart mid-layer.
    beat(rnd_data());
    @(negedge clk);
    check("idle_beat_wr_en", 256'(bus.wr_en), 256'(0));
    check("idle_beat_err",   256'(bus.err),   256'(1));
    start_layer(3'd5, 6'd1, 1'b1);
    beats(100, 1'b0);
    bus.start = 1'b1;
    beat(rnd_data());
    bus.start = 1'b0;
    beats(406, 1'b1);
    wait_done("proto");
    layer_check("proto", 169, 675, 507);
    check("proto_err", 256'(bus.err), 256'(1));

    // Reset mid-layer, then a fresh layer.
    start_layer(3'd0, 6'd5, 1'b0);
    beats(100, 1'b0);
    rst = 1'b0;
    tick();
    check_all_zero("midreset");
    rst = 1'b1;
    tick();
    tick();
    start_layer(3'd2, 6'd2, 1'b0);
    beats(1458, 1'b1);
    wait_done("l4");
    layer_check("l4", 1458, 2915, 1458);
    check("l4_err", 256'(bus.err), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/expand_writeback.md
EXPAND_WRITEBACK -- requirements
Module: expand_writeback

Interface
REQ-001 Parameter: LANES, default 16, number of parallel 16-bit filter outputs per beat.
REQ-002 Parameter: AW, default 32, write-address width in LANES-word units.
REQ-003 Port: clk  input  1  system clock; all logic rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: firesel  input  3  fire configuration select; latched on start.
REQ-006 Port: chbase  input  6  channel base in 16-channel groups, for concat placement; latched on start.
REQ-007 Port: start  input  1  single-cycle pulse that begins a layer.
REQ-008 Port: in_valid  input  1  upstream 1x1-expand beat valid.
REQ-009 Port: in_data  input  LANES*16  16 signed lanes; lane k occupies bits [16k+15:16k].
REQ-010 Port: wr_en  output  1  output-buffer write strobe.
REQ-011 Port: wr_addr  output  AW  output-buffer word address.
REQ-012 Port: wr_data  output  LANES*16  processed lanes.
REQ-013 Port: busy  output  1  high in RUN.
REQ-014 Port: done  output  1  one-cycle pulse after the final write.
REQ-015 Port: err  output  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL use the firesel table (inputsize S, filtersize F): 0:55/64, 1:55/16, 2:27/32, 3:27/32, 4:13/48, 5:13/48, 6:13/64, 7:13/64.
REQ-017 The block SHALL set NPIX=S*S, NGRP=F/16 and TOTAL=NPIX*NGRP, computed from the latched firesel.
REQ-018 The FSM SHALL have states IDLE, RUN and FIN.
- IDLE->RUN on start.
- RUN->FIN on the accepted beat with index TOTAL-1.
- FIN->IDLE unconditionally after one cycle.
REQ-019 On start in IDLE, the block SHALL latch firesel and chbase, clear the pixel counter p and the group counter g, and load base=chbase*NPIX.
REQ-020 Beat ordering SHALL be group-major: p increments on every accepted beat; at p=NPIX-1, p wraps to 0 and g increments.
REQ-021 A beat accepted with counters (g,p) SHALL be written at wr_addr=base+g*NPIX+p.
REQ-022 Latency SHALL be one cycle: in_valid high in RUN at cycle N gives wr_en=1 at N+1, with that beat's address and data.
REQ-023 Gaps in in_valid SHALL be tolerated with no effect on the counters.
REQ-024 Back-to-back valid beats SHALL produce back-to-back writes.
REQ-025 done SHALL pulse in FIN, the same cycle as the final wr_en.
REQ-026 busy SHALL be high in RUN only.
REQ-027 A start pulse in RUN or FIN SHALL be ignored and SHALL set err.
REQ-028 in_valid in IDLE or FIN SHALL produce no write and SHALL set err.
REQ-029 Simultaneous start and in_valid in IDLE: the block SHALL start, SHALL drop the beat and SHALL set err.
REQ-030 Changes to firesel or chbase after start SHALL have no effect until the next start.
REQ-031 err SHALL clear only on reset.

Reset
REQ-032 On rst=0 at a clock edge, the block SHALL reset the following, including mid-layer:
- state=IDLE, p=0, g=0, base=0;
- wr_en=0, wr_addr=0, wr_data=0;
- busy=0, done=0, err=0.
REQ-033 After reset, no write from an interrupted layer SHALL occur.

Configuration
REQ-034 With macro EXPAND_WRITEBACK_RELU_EN defined, each lane SHALL be ReLU-processed: a lane with bit15=1 is written as 0x0000; otherwise it is written unchanged.
REQ-035 Without EXPAND_WRITEBACK_RELU_EN, wr_data SHALL equal the registered in_data bit-exactly; addressing and timing SHALL be identical in both builds.

Verification
REQ-036 Layer 1: firesel=1, chbase=0, start, then 3025 consecutive valid beats -> writes to addresses 0..3024, done in the cycle of the address-3024 write, then IDLE.
REQ-037 Layer 2: firesel=4, chbase=3, 507 beats with random gaps -> first address 507; beat 169 at address 676; last address 1013; exactly 507 writes.
REQ-038 Layer 3: RELU_EN build, lanes 0x8001, 0x7FFF, 0x0000, 0xFFFF -> written as 0x0000, 0x7FFF, 0x0000, 0x0000; non-RELU build -> written unchanged.
REQ-039 Protocol: in_valid=1 in IDLE -> no wr_en, err=1; a start mid-RUN -> the counters continue unaffected and err stays 1.
REQ-040 Reset: rst=0 after 100 beats of firesel=0 -> all outputs 0; a new start with firesel=2, chbase=2 -> first address 1458, 1458 writes, done.
